// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB encodings, arbiter state names and burst-length decode used by the
// bus arbiter and its round-robin picker.
package ahb_bus_arbiter_pkg;

    localparam int MAX_MASTERS = 4;
    localparam int BEAT_W      = 5;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    // Undefined-length INCR is treated as a single beat for handover purposes.
    function automatic logic [BEAT_W-1:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HB_WRAP4,  HB_INCR4:  burst_len = BEAT_W'(4);
            HB_WRAP8,  HB_INCR8:  burst_len = BEAT_W'(8);
            HB_WRAP16, HB_INCR16: burst_len = BEAT_W'(16);
            default:              burst_len = BEAT_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration-side AHB signals: requests/locks and muxed bus status in,
// grant and address-phase ownership out.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic [2:0]             HBURST;
    logic                   HREADY;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [1:0]             HMASTER;
    logic                   HMASTLOCK;

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational winner selection: masked-priority round-robin after last_owner,
// or plain lowest-index priority when rr_mode is low.
module ahb_rr_picker #(
    parameter int NUM_MASTERS    = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int IDX_W          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_owner,
    input  logic                   rr_mode,
    output logic [IDX_W-1:0]       winner
);

    logic [NUM_MASTERS-1:0] masked;

    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            masked[i] = req[i] && (!rr_mode || (i > int'(last_owner)));
        end
    end

    // Descending scans leave the lowest set index; any masked hit overrides
    // the unmasked one, which is what makes the search wrap past last_owner.
    always_comb begin
        winner = IDX_W'(DEFAULT_MASTER);
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) winner = IDX_W'(i);
        end
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (masked[i]) winner = IDX_W'(i);
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: registered one-hot grant, burst-aware handover, locked
// sequences, and HREADY-gated address-phase ownership (HMASTER/HMASTLOCK).
module ahb_bus_arbiter
    import ahb_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int ROUND_ROBIN    = 1
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ahb_bus_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [IDX_W-1:0]       DEF_IDX   = IDX_W'(DEFAULT_MASTER);

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [IDX_W-1:0]       owner, winner;
    logic [1:0]             hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [BEAT_W-1:0]      cnt_q, cnt_d;
    arb_state_e             state_q, state_d;
    logic                   unlock_q, unlock_d;
    logic                   arb_ok, fixed_burst;

    ahb_rr_picker #(
        .NUM_MASTERS    (NUM_MASTERS),
        .DEFAULT_MASTER (DEFAULT_MASTER)
    ) u_picker (
        .req        (bus.HBUSREQ),
        .last_owner (last_q),
        .rr_mode    (ROUND_ROBIN != 0),
        .winner     (winner)
    );

    always_comb begin
        owner = DEF_IDX;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) owner = IDX_W'(i);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.HREADY) begin
            case (bus.HTRANS)
                HT_NONSEQ: cnt_d = burst_len(bus.HBURST);
                HT_SEQ:    cnt_d = (cnt_q == '0) ? '0 : cnt_q - BEAT_W'(1);
                HT_IDLE:   cnt_d = '0;
                default:   cnt_d = cnt_q;
            endcase
        end
    end

    // Handover is judged on the beats left after this transfer, so the grant
    // moves during the last beat's address phase and never on a burst's NONSEQ.
    assign arb_ok = bus.HREADY && (state_q != ST_LOCKED) &&
                    ((cnt_d <= BEAT_W'(1)) || (bus.HTRANS == HT_IDLE) ||
                     (bus.HBURST == HB_INCR));

    assign fixed_burst = bus.HREADY && (bus.HTRANS == HT_NONSEQ) &&
                         (bus.HBURST != HB_SINGLE) && (bus.HBURST != HB_INCR);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        unlock_d = unlock_q;
        case (state_q)
            ST_ARB, ST_BURST: begin
                if (arb_ok) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    last_d          = winner;
                    state_d         = bus.HLOCK[winner] ? ST_LOCKED : ST_ARB;
                end else if (fixed_burst) begin
                    state_d = ST_BURST;
                end
            end
            ST_LOCKED: begin
                // Once HLOCK drops, one more accepted transfer closes the sequence.
                if (unlock_q && bus.HREADY) begin
                    state_d  = ST_ARB;
                    unlock_d = 1'b0;
                end else if (!bus.HLOCK[owner]) begin
                    unlock_d = 1'b1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_comb begin
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (bus.HREADY) begin
            hmaster_d   = 2'(owner);
            hmastlock_d = bus.HLOCK[owner];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q     <= DEF_GRANT;
            last_q      <= DEF_IDX;
            hmaster_q   <= 2'(DEFAULT_MASTER);
            hmastlock_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_ARB;
            unlock_q    <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            last_q      <= last_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            unlock_q    <= unlock_d;
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = hmaster_q;
    assign bus.HMASTLOCK = hmastlock_q;

endmodule
